// File: rtl/button_events_pkg.sv
// Shared types for button_events: event kinds, per-button FSM states and the queued event record.
package button_events_pkg;

    // Width of the button index carried in a queued event; covers up to 256 buttons.
    localparam int BTN_IDX_MAX_W = 8;

    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        RELEASE = 2'd1,
        HOLD    = 2'd2,
        REPEAT  = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    typedef struct packed {
        logic [BTN_IDX_MAX_W-1:0] btn;
        evt_kind_t                kind;
    } event_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through queue; pointers carry an extra wrap bit to tell full from empty.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] w_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] r_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop on a full queue frees the slot the push lands in during the same cycle.
    assign do_push = push & (~full | do_pop);
    assign r_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/button_events.sv
// Turns debounced button levels into queued PRESS/RELEASE/HOLD events.
// Define BUTTON_EVENTS_REPEAT_EN to also emit REPEAT every REPEAT_CYCLES while a button stays held.
module button_events
    import button_events_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_btn,
    output logic [1:0]               evt_kind,
    output logic                     overflow
);
    localparam int BTN_W = $clog2(N_BTN);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

    logic [N_BTN-1:0] slot_valid;
    evt_kind_t        slot_kind [N_BTN];
    logic [N_BTN-1:0] grant;
    logic [N_BTN-1:0] drop;
    event_t           push_evt;
    event_t           head;
    logic             head_unused;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_space;
    logic             push;
    logic             pop;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_state_t     state;
        logic [CNT_W-1:0] cnt;
        logic           prev;
        logic           rise;
        logic           fall;
        logic           hold_hit;
        logic           fire;
        evt_kind_t      kind;
        logic           slot_v;
        evt_kind_t      slot_k;

        assign rise     = btn_in[i] & ~prev;
        assign fall     = ~btn_in[i] & prev;
        assign hold_hit = (cnt == CNT_W'(HOLD_CYCLES - 1));
`ifdef BUTTON_EVENTS_REPEAT_EN
        logic rep_hit;
        assign rep_hit = (cnt == CNT_W'(REPEAT_CYCLES - 1));
`endif

        // A fall always wins over a timer expiry on the same cycle.
        always_comb begin
            fire = 1'b0;
            kind = PRESS;
            case (state)
                IDLE: begin
                    if (rise) begin
                        fire = 1'b1;
                        kind = PRESS;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        fire = 1'b1;
                        kind = RELEASE;
                    end else if (hold_hit) begin
                        fire = 1'b1;
                        kind = HOLD;
                    end
                end
                HELD: begin
                    if (fall) begin
                        fire = 1'b1;
                        kind = RELEASE;
                    end
`ifdef BUTTON_EVENTS_REPEAT_EN
                    else if (rep_hit) begin
                        fire = 1'b1;
                        kind = REPEAT;
                    end
`endif
                end
                default: ;
            endcase
        end

        // A slot being drained by the arbiter this cycle counts as free for the new event.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state  <= IDLE;
                cnt    <= '0;
                prev   <= 1'b0;
                slot_v <= 1'b0;
                slot_k <= PRESS;
            end else begin
                prev <= btn_in[i];
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (fall) begin
                            state <= IDLE;
                        end else if (hold_hit) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (fall) begin
                            state <= IDLE;
                        end
`ifdef BUTTON_EVENTS_REPEAT_EN
                        else if (rep_hit) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
                if (fire && (!slot_v || grant[i])) begin
                    slot_v <= 1'b1;
                    slot_k <= kind;
                end else if (grant[i]) begin
                    slot_v <= 1'b0;
                end
            end
        end

        assign slot_valid[i] = slot_v;
        assign slot_kind[i]  = slot_k;
        assign drop[i]       = fire & slot_v & ~grant[i];
    end

    assign pop        = evt_valid & evt_ready;
    assign fifo_space = ~fifo_full | pop;

    // Fixed priority: the lowest-index occupied slot goes to the queue.
    always_comb begin
        grant    = '0;
        push_evt = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (slot_valid[i] && fifo_space) begin
                grant         = '0;
                grant[i]      = 1'b1;
                push_evt.btn  = BTN_IDX_MAX_W'(i);
                push_evt.kind = slot_kind[i];
            end
        end
    end

    assign push = |grant;

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(event_t))
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .w_data (push_evt),
        .full   (fifo_full),
        .pop    (pop),
        .r_data (head),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end
    end

    assign evt_valid   = ~fifo_empty;
    assign evt_btn     = evt_valid ? head.btn[BTN_W-1:0] : '0;
    assign evt_kind    = evt_valid ? head.kind : 2'd0;
    assign head_unused = |head.btn;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with HOLD_CYCLES=10, REPEAT_CYCLES=4, FIFO_DEPTH=4.
// HELD-state expectations follow BUTTON_EVENTS_REPEAT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_button_events;
    localparam int N_BTN         = 4;
    localparam int HOLD_CYCLES   = 10;
    localparam int REPEAT_CYCLES = 4;
    localparam int FIFO_DEPTH    = 4;

    localparam logic [1:0] K_PRESS   = 2'd0;
    localparam logic [1:0] K_RELEASE = 2'd1;
    localparam logic [1:0] K_HOLD    = 2'd2;
    localparam logic [1:0] K_REPEAT  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_btn;
    logic [1:0] evt_kind;
    logic       overflow;

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_btn;
        logic [1:0] exp_kind;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        int         t;
        logic [1:0] b;
        logic [1:0] k;
    } ev_t;

    vec_t vecs [16];
    ev_t  obs [$];
    ev_t  exp_ev [$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    button_events #(
        .N_BTN         (N_BTN),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_kind  (evt_kind),
        .overflow  (overflow)
    );

    // Drive inputs, let one rising edge sample them, then settle before looking at outputs.
    task automatic applyStimulus(input logic [3:0] b, input logic r);
        btn_in    = b;
        evt_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare the recorded event stream against the expected one, optionally including timing.
    task automatic checkEvents(input string name, input bit with_time);
        checkOutput({name, "_count"}, obs.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size(); i++) begin
            if (i < obs.size()) begin
                if (with_time) checkOutput($sformatf("%s_t%0d", name, i), obs[i].t, exp_ev[i].t);
                checkOutput($sformatf("%s_btn%0d", name, i), obs[i].b, exp_ev[i].b);
                checkOutput($sformatf("%s_kind%0d", name, i), obs[i].k, exp_ev[i].k);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;

        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[1]  = '{4'b0100, 1'b1, 1'b1, 2'd2, K_PRESS,   1'b0};
        vecs[2]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[3]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[4]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[6]  = '{4'b0000, 1'b1, 1'b1, 2'd2, K_RELEASE, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[8]  = '{4'b1001, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[9]  = '{4'b1001, 1'b1, 1'b1, 2'd0, K_PRESS,   1'b0};
        vecs[10] = '{4'b1001, 1'b0, 1'b1, 2'd0, K_PRESS,   1'b0};
        vecs[11] = '{4'b1001, 1'b1, 1'b1, 2'd3, K_PRESS,   1'b0};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};
        vecs[13] = '{4'b0000, 1'b1, 1'b1, 2'd0, K_RELEASE, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 1'b1, 2'd3, K_RELEASE, 1'b0};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0,      1'b0};

        // Reset state
        rst_n     = 1'b0;
        btn_in    = 4'b0000;
        evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", evt_valid, 1'b0);
        checkOutput("reset_btn", evt_btn, 2'd0);
        checkOutput("reset_kind", evt_kind, 2'd0);
        checkOutput("reset_overflow", overflow, 1'b0);

        // Idle buttons must never produce an event
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(4'b0000, 1'b1);
            if (evt_valid !== 1'b0) seen++;
        end
        checkOutput("idle_valid_cycles", seen, 0);
        checkOutput("idle_overflow", overflow, 1'b0);

        // Short press, simultaneous presses, consumer stall
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), evt_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_btn", i), evt_btn, vecs[i].exp_btn);
                checkOutput($sformatf("vec%0d_kind", i), evt_kind, vecs[i].exp_kind);
            end
            checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
        end

        // Long press on button 1: event appears one edge after entering its slot
        obs.delete();
        exp_ev.delete();
        for (int c = 0; c < 30; c++) begin
            applyStimulus((c < 25) ? 4'b0010 : 4'b0000, 1'b1);
            if (evt_valid === 1'b1) obs.push_back('{c, evt_btn, evt_kind});
        end
        exp_ev.push_back('{1, 2'd1, K_PRESS});
        exp_ev.push_back('{11, 2'd1, K_HOLD});
`ifdef BUTTON_EVENTS_REPEAT_EN
        exp_ev.push_back('{15, 2'd1, K_REPEAT});
        exp_ev.push_back('{19, 2'd1, K_REPEAT});
        exp_ev.push_back('{23, 2'd1, K_REPEAT});
`endif
        exp_ev.push_back('{26, 2'd1, K_RELEASE});
        checkEvents("long_press", 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b1);

        // Backlog with a stalled consumer: queue fills, slots hold the rest, excess is dropped
        applyStimulus(4'b0011, 1'b0);
        checkOutput("ovf_before_drop", overflow, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("ovf_after_drop", overflow, 1'b1);
        for (int c = 2; c < 6; c++) applyStimulus((c % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0);
        checkOutput("ovf_stall_valid", evt_valid, 1'b1);
        checkOutput("ovf_stall_btn", evt_btn, 2'd0);
        checkOutput("ovf_stall_kind", evt_kind, K_PRESS);

        obs.delete();
        exp_ev.delete();
        for (int c = 0; c < 10; c++) begin
            if (evt_valid === 1'b1) obs.push_back('{c, evt_btn, evt_kind});
            applyStimulus(4'b0000, 1'b1);
        end
        exp_ev.push_back('{0, 2'd0, K_PRESS});
        exp_ev.push_back('{0, 2'd0, K_RELEASE});
        exp_ev.push_back('{0, 2'd0, K_PRESS});
        exp_ev.push_back('{0, 2'd0, K_RELEASE});
        exp_ev.push_back('{0, 2'd0, K_PRESS});
        exp_ev.push_back('{0, 2'd1, K_PRESS});
        checkEvents("drain", 1'b0);
        checkOutput("drain_valid", evt_valid, 1'b0);
        checkOutput("drain_overflow", overflow, 1'b1);

        // Reset pulse discards a queued event and clears the sticky flag
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("rst_pre_valid", evt_valid, 1'b1);
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("rst_pulse_valid", evt_valid, 1'b0);
        checkOutput("rst_pulse_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b0000, 1'b1);
            if (evt_valid !== 1'b0) seen++;
        end
        checkOutput("rst_quiet_cycles", seen, 0);

        // A button held across reset release reports a fresh PRESS
        rst_n = 1'b0;
        applyStimulus(4'b0100, 1'b1);
        rst_n = 1'b1;
        applyStimulus(4'b0100, 1'b1);
        checkOutput("held_rst_slot_valid", evt_valid, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("held_rst_valid", evt_valid, 1'b1);
        checkOutput("held_rst_btn", evt_btn, 2'd2);
        checkOutput("held_rst_kind", evt_kind, K_PRESS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
